or_word_bist: RTL

Built-in self-test engine for the 20-bit `or_word` ALU slice. It generates pseudo-random operand pairs and drives them into the slice under test. It reads back `c` and `zero`, checks them against an internal golden OR model, and reports a pass/fail verdict with an error count. It sits beside the ALU and is started by the debug/test controller; during normal CPU operation it is idle and its operand outputs hold.

---
 rtl/or_word_bist.sv | 121 ++++++++++++
 1 files changed

// File: rtl/or_word_bist.sv
// Built-in self-test engine for the or_word ALU slice: drives LFSR operand pairs,
// checks c/zero against a golden OR one cycle later, and reports a verdict.
module or_word_bist #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned NUM_ITERS = 10,
  parameter int unsigned SEED      = 49448
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_c,
  input  logic             dut_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic [15:0]      first_fail_iter
);

  localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_A    = (SEED_W == '0) ? ONE_W : SEED_W;
  localparam logic [WIDTH-1:0] SEED_B    = (~SEED_W == '0) ? ONE_W : ~SEED_W;
  localparam logic [15:0]      ITER_LAST = 16'(NUM_ITERS - 1);
  localparam logic [15:0]      NO_FAIL   = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [15:0]      iter_q;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_b_q;
  logic [WIDTH-1:0] dut_a_q, dut_b_q;
  logic             busy_q, done_q, pass_q;
  logic [15:0]      fail_count_q, first_fail_iter_q;

  logic [WIDTH-1:0] golden_c;
  logic             golden_z;
  logic             mismatch;
  logic [15:0]      fail_count_d;

  // Fibonacci x^20+x^17+1: shift left, feedback from the top bit and the bit three below it
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], s[WIDTH-1] ^ s[WIDTH-4]};
  endfunction

  // Operands registered last edge have had a full cycle to settle through or_word
  always_comb begin
    golden_c     = dut_a_q | dut_b_q;
    golden_z     = (golden_c == '0);
    mismatch     = (dut_c != golden_c) || (dut_zero != golden_z);
    fail_count_d = fail_count_q;
    if (mismatch && (fail_count_q != 16'hFFFF)) begin
      fail_count_d = fail_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      iter_q            <= '0;
      lfsr_a_q          <= SEED_A;
      lfsr_b_q          <= SEED_B;
      dut_a_q           <= '0;
      dut_b_q           <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      fail_count_q      <= '0;
      first_fail_iter_q <= NO_FAIL;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dut_a_q           <= lfsr_a_q;
            dut_b_q           <= lfsr_b_q;
            lfsr_a_q          <= lfsr_step(lfsr_a_q);
            lfsr_b_q          <= lfsr_step(lfsr_b_q);
            iter_q            <= '0;
            fail_count_q      <= '0;
            first_fail_iter_q <= NO_FAIL;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            state_q           <= S_RUN;
          end
        end
        S_RUN: begin
          fail_count_q <= fail_count_d;
          if (mismatch && (first_fail_iter_q == NO_FAIL)) begin
            first_fail_iter_q <= iter_q;
          end
          if (iter_q == ITER_LAST) begin
            // Operands hold on the last iteration; LFSRs are not stepped again
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_count_d == 16'd0);
          end else begin
            iter_q   <= iter_q + 16'd1;
            dut_a_q  <= lfsr_a_q;
            dut_b_q  <= lfsr_b_q;
            lfsr_a_q <= lfsr_step(lfsr_a_q);
            lfsr_b_q <= lfsr_step(lfsr_b_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a           = dut_a_q;
  assign dut_b           = dut_b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_count      = fail_count_q;
  assign first_fail_iter = first_fail_iter_q;

endmodule
